// File: rtl/chip8_uart_loader.sv
// chip8_uart_loader: frames a CHIP-8 program image from UART bytes into program RAM, then releases the CPU.
// Latency: each payload byte raises a RAM write request on the cycle after its rx strobe.
// Backpressure: rx has none; a byte arriving while a write is still unacknowledged aborts the load (overrun).
// Ports: clk_i/rst_i (async active-high); rx_data_i/rx_valid_i byte strobe; restart_i leaves DONE/ERR;
//        mem_addr_o/mem_data_o/mem_we_o/mem_ack_i RAM write port; cpu_rst_o, done_o, err_o, err_code_o status.
// Frame: 2-byte big-endian length, then payload written from BASE_ADDR upward.
// Optional: define CHIP8_LOADER_CSUM_EN to require a trailing modulo-256 checksum byte (err_code 4 on mismatch).
module chip8_uart_loader #(
  parameter int             AW             = 12,
  parameter logic [AW-1:0]  BASE_ADDR      = 12'h200,
  parameter int             MAX_LEN        = 3584,
  parameter int             TIMEOUT_CYCLES = 1200000
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [7:0]    rx_data_i,
  input  logic          rx_valid_i,
  input  logic          restart_i,
  output logic [AW-1:0] mem_addr_o,
  output logic [7:0]    mem_data_o,
  output logic          mem_we_o,
  input  logic          mem_ack_i,
  output logic          cpu_rst_o,
  output logic          done_o,
  output logic          err_o,
  output logic [2:0]    err_code_o
);

  localparam int            TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0]   MAX_LEN_W = 16'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
`ifdef CHIP8_LOADER_CSUM_EN
    S_CSUM   = 3'd4,
`endif
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  // State that follows the last payload write (or an empty payload).
`ifdef CHIP8_LOADER_CSUM_EN
  localparam state_t S_POST = S_CSUM;
`else
  localparam state_t S_POST = S_DONE;
`endif

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic          we_q, we_d;
  logic          cpu_rst_q, cpu_rst_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [2:0]    err_code_q, err_code_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [7:0]    len_hi_q, len_hi_d;
  logic [TW-1:0] tmo_q, tmo_d;
`ifdef CHIP8_LOADER_CSUM_EN
  logic [7:0]    sum_q, sum_d;
`endif

  logic [15:0] len_w;
  logic        tmo_hit;
  logic [2:0]  errc;   // code to latch when the next state is ERR

  assign len_w   = {len_hi_q, rx_data_i};
  // A byte in the same cycle as the limit clears the counter instead of timing out.
  assign tmo_hit = (tmo_q == TMO_LAST) && !rx_valid_i;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      addr_q     <= BASE_ADDR;
      data_q     <= 8'd0;
      we_q       <= 1'b0;
      cpu_rst_q  <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 3'd0;
      cnt_q      <= 16'd0;
      len_hi_q   <= 8'd0;
      tmo_q      <= '0;
`ifdef CHIP8_LOADER_CSUM_EN
      sum_q      <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      we_q       <= we_d;
      cpu_rst_q  <= cpu_rst_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      cnt_q      <= cnt_d;
      len_hi_q   <= len_hi_d;
      tmo_q      <= tmo_d;
`ifdef CHIP8_LOADER_CSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    errc    = 3'd0;
    case (state_q)
      S_IDLE, S_LEN_HI: begin
        if (rx_valid_i)                state_d = S_LEN_LO;
        else if (state_q == S_LEN_HI)  state_d = S_IDLE;
      end
      S_LEN_LO: begin
        if (rx_valid_i) begin
          if (len_w == 16'd0)          state_d = S_POST;
          else if (len_w > MAX_LEN_W) begin state_d = S_ERR; errc = 3'd1; end
          else                         state_d = S_DATA;
        end else if (tmo_hit) begin
          state_d = S_ERR; errc = 3'd3;
        end
      end
      S_DATA: begin
        if (tmo_hit) begin
          state_d = S_ERR; errc = 3'd3;
        end else if (rx_valid_i && we_q && !mem_ack_i) begin
          state_d = S_ERR; errc = 3'd2;
        end else if (we_q && mem_ack_i && cnt_q == 16'd1) begin
`ifdef CHIP8_LOADER_CSUM_EN
          // A byte alongside the final ack is already the checksum byte.
          if (rx_valid_i) begin
            if (rx_data_i == sum_q) state_d = S_DONE;
            else begin state_d = S_ERR; errc = 3'd4; end
          end else begin
            state_d = S_CSUM;
          end
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef CHIP8_LOADER_CSUM_EN
      S_CSUM: begin
        if (rx_valid_i) begin
          if (rx_data_i == sum_q) state_d = S_DONE;
          else begin state_d = S_ERR; errc = 3'd4; end
        end else if (tmo_hit) begin
          state_d = S_ERR; errc = 3'd3;
        end
      end
`endif
      S_DONE, S_ERR: begin
        if (restart_i) state_d = S_LEN_HI;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    addr_d     = addr_q;
    data_d     = data_q;
    we_d       = we_q;
    cpu_rst_d  = cpu_rst_q;
    done_d     = done_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    cnt_d      = cnt_q;
    len_hi_d   = len_hi_q;
    tmo_d      = tmo_q;
`ifdef CHIP8_LOADER_CSUM_EN
    sum_d      = sum_q;
`endif
    case (state_q)
      S_IDLE, S_LEN_HI: begin
        if (rx_valid_i) len_hi_d = rx_data_i;
      end
      S_LEN_LO: begin
`ifdef CHIP8_LOADER_CSUM_EN
        sum_d = 8'd0;
`endif
        if (state_d == S_DATA) begin
          cnt_d  = len_w;
          addr_d = BASE_ADDR;
        end
      end
      S_DATA: begin
        if (state_d == S_DATA) begin
          if (we_q && mem_ack_i) begin
            addr_d = addr_q + AW'(1);
            cnt_d  = cnt_q - 16'd1;
            we_d   = 1'b0;
          end
          // Capture on an idle port, or back-to-back with the ack of the previous byte.
          if (rx_valid_i && (!we_q || mem_ack_i)) begin
            data_d = rx_data_i;
            we_d   = 1'b1;
`ifdef CHIP8_LOADER_CSUM_EN
            sum_d  = sum_q + rx_data_i;
`endif
          end
        end else begin
          // Leaving DATA: the final ack still counts unless a timeout pre-empted it.
          // The address is left on the last byte so it never steps past the RAM top.
          if (we_q && mem_ack_i && errc != 3'd3) cnt_d = cnt_q - 16'd1;
          we_d = 1'b0;
        end
      end
      S_DONE, S_ERR: begin
        if (state_d == S_LEN_HI) begin
          done_d     = 1'b0;
          err_d      = 1'b0;
          err_code_d = 3'd0;
          cpu_rst_d  = 1'b1;
          addr_d     = BASE_ADDR;
        end
      end
      default: ;
    endcase

    if (state_d == S_DONE && state_q != S_DONE) begin
      done_d    = 1'b1;
      cpu_rst_d = 1'b0;
      we_d      = 1'b0;
    end
    if (state_d == S_ERR && state_q != S_ERR) begin
      err_d      = 1'b1;
      err_code_d = errc;
      cpu_rst_d  = 1'b1;
      we_d       = 1'b0;
    end

    if (rx_valid_i || state_d != state_q)
      tmo_d = '0;
    else if (state_q == S_LEN_LO || state_q == S_DATA
`ifdef CHIP8_LOADER_CSUM_EN
             || state_q == S_CSUM
`endif
            )
      tmo_d = tmo_q + TW'(1);
  end

  assign mem_addr_o = addr_q;
  assign mem_data_o = data_q;
  assign mem_we_o   = we_q;
  assign cpu_rst_o  = cpu_rst_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign err_code_o = err_code_q;

endmodule

// File: tb/tb_chip8_uart_loader.sv
// tb_chip8_uart_loader: directed frames into chip8_uart_loader with a scoreboard of expected RAM writes
// and expected terminal status; a monitor pops and compares on every accepted write and every rise of done/err.
module tb_chip8_uart_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        restart = 1'b0;
  logic [11:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_we;
  logic        mem_ack;
  logic        cpu_rst;
  logic        done;
  logic        err;
  logic [2:0]  err_code;
  logic        ack_en = 1'b1;
  logic        sim_done = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [19:0] wq[$];   // {addr, data}
  logic [5:0]  sq[$];   // {done, err, code[2:0], cpu_rst}

  // RAM model: acknowledges in the same cycle as the request when enabled.
  assign mem_ack = ack_en & mem_we;

  always #5 clk = ~clk;

  chip8_uart_loader #(
    .AW(12), .BASE_ADDR(12'h200), .MAX_LEN(3584), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk_i(clk), .rst_i(rst), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .restart_i(restart), .mem_addr_o(mem_addr), .mem_data_o(mem_data),
    .mem_we_o(mem_we), .mem_ack_i(mem_ack), .cpu_rst_o(cpu_rst),
    .done_o(done), .err_o(err), .err_code_o(err_code)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    repeat (gap) step();
  endtask

  task automatic send_csum(input logic [7:0] b);
`ifdef CHIP8_LOADER_CSUM_EN
    send(b, 2);
`else
    if (b === 8'hxx) $display("unused checksum %0h", b);
`endif
  endtask

  task automatic wait_flag(input string nm, input int max);
    int i;
    i = 0;
    while (!(done || err) && i < max) begin
      step();
      i++;
    end
    if (!(done || err)) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: got no done/err within %0d cycles required done or err", nm, max);
    end
  endtask

  task automatic do_restart(input string nm);
    restart = 1'b1;
    step();
    restart = 1'b0;
    step();
    chk({nm, "_done_clr"}, done, 1'b0);
    chk({nm, "_err_clr"},  {err, err_code}, 4'h0);
    chk({nm, "_cpu_rst"},  cpu_rst, 1'b1);
    chk({nm, "_addr"},     mem_addr, 12'h200);
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, "_addr"},    mem_addr, 12'h200);
    chk({nm, "_data"},    mem_data, 8'h00);
    chk({nm, "_we"},      mem_we,   1'b0);
    chk({nm, "_cpu_rst"}, cpu_rst,  1'b1);
    chk({nm, "_done"},    done,     1'b0);
    chk({nm, "_err"},     err,      1'b0);
    chk({nm, "_code"},    err_code, 3'd0);
  endtask

  task automatic monitor_loop();
    logic        flag_prev;
    logic [19:0] we_exp;
    logic [5:0]  st_exp;
    flag_prev = 1'b0;
    while (!sim_done) begin
      @(negedge clk);
      if (rst) begin
        flag_prev = 1'b0;
      end else begin
        if (mem_we && mem_ack) begin
          if (wq.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_write: got addr %0h data %0h required no write", mem_addr, mem_data);
          end else begin
            we_exp = wq.pop_front();
            chk("ram_write", {mem_addr, mem_data}, we_exp);
          end
        end
        if ((done || err) && !flag_prev) begin
          if (sq.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_status: got done %0b err %0b code %0d required none", done, err, err_code);
          end else begin
            st_exp = sq.pop_front();
            chk("status", {done, err, err_code, cpu_rst}, st_exp);
          end
        end
        flag_prev = done || err;
      end
    end
  endtask

  task automatic stimulus();
    // Reset values
    #2 rst = 1'b1;
    #1 check_reset_vals("reset");
    step();
    step();
    rst = 1'b0;
    step();

    // T1: three-byte frame, ack same cycle as request
    wq.push_back({12'h200, 8'hA1});
    wq.push_back({12'h201, 8'hB2});
    wq.push_back({12'h202, 8'hC3});
    sq.push_back({1'b1, 1'b0, 3'd0, 1'b0});
    send(8'h00, 1); send(8'h03, 1);
    send(8'hA1, 2); send(8'hB2, 2); send(8'hC3, 2);
    send_csum(8'h16);
    wait_flag("t1_wait", 50);
    chk("t1_cpu_rst", cpu_rst, 1'b0);
    send(8'h99, 2);   // ignored in DONE
    chk("t1_done_hold", {done, err}, 2'b10);
    do_restart("t1_restart");

    // T2: over-length
    sq.push_back({1'b0, 1'b1, 3'd1, 1'b1});
    send(8'h0E, 1); send(8'h01, 1);
    wait_flag("t2_wait", 20);
    chk("t2_no_we", mem_we, 1'b0);
    do_restart("t2_restart");

    // T3: overrun while the first write is still unacknowledged
    ack_en = 1'b0;
    sq.push_back({1'b0, 1'b1, 3'd2, 1'b1});
    send(8'h00, 1); send(8'h02, 1);
    send(8'h55, 4);
    chk("t3_we_held", mem_we, 1'b1);
    send(8'h66, 0);
    chk("t3_we_drop", mem_we, 1'b0);
    chk("t3_err", {err, err_code}, 4'hA);
    ack_en = 1'b1;
    step();
    do_restart("t3_restart");

    // T4: inter-byte timeout, exact cycle, then empty frame
    wq.push_back({12'h200, 8'h11});
    sq.push_back({1'b0, 1'b1, 3'd3, 1'b1});
    send(8'h00, 1); send(8'h05, 1);
    send(8'h11, 0);
    repeat (99) step();
    chk("t4_not_yet", err, 1'b0);
    step();
    chk("t4_timeout", {err, err_code}, 4'hB);
    do_restart("t4_restart");
    sq.push_back({1'b1, 1'b0, 3'd0, 1'b0});
    send(8'h00, 1); send(8'h00, 1);
    send_csum(8'h00);
    wait_flag("t4_empty_wait", 20);
    do_restart("t4_restart2");

    // T5: asynchronous reset mid-DATA, then a fresh one-byte frame
    wq.push_back({12'h200, 8'h01});
    wq.push_back({12'h201, 8'h02});
    send(8'h00, 1); send(8'h04, 1);
    send(8'h01, 2); send(8'h02, 3);
    #2 rst = 1'b1;
    #1 check_reset_vals("t5_async_reset");
    step();
    rst = 1'b0;
    step();
    wq.push_back({12'h200, 8'h5A});
    sq.push_back({1'b1, 1'b0, 3'd0, 1'b0});
    send(8'h00, 1); send(8'h01, 1); send(8'h5A, 2);
    send_csum(8'h5A);
    wait_flag("t5_wait", 20);
    do_restart("t5_restart");

    // T6: back-to-back payload bytes, rx coincident with ack
    wq.push_back({12'h200, 8'h77});
    wq.push_back({12'h201, 8'h88});
    sq.push_back({1'b1, 1'b0, 3'd0, 1'b0});
    send(8'h00, 1); send(8'h02, 1);
    send(8'h77, 0); send(8'h88, 2);
    send_csum(8'hFF);
    wait_flag("t6_wait", 20);
    do_restart("t6_restart");

`ifdef CHIP8_LOADER_CSUM_EN
    // T7: checksum good and bad
    wq.push_back({12'h200, 8'h10});
    wq.push_back({12'h201, 8'h20});
    sq.push_back({1'b1, 1'b0, 3'd0, 1'b0});
    send(8'h00, 1); send(8'h02, 1); send(8'h10, 2); send(8'h20, 2);
    send(8'h30, 2);
    wait_flag("t7_good_wait", 20);
    do_restart("t7_restart");
    wq.push_back({12'h200, 8'h10});
    wq.push_back({12'h201, 8'h20});
    sq.push_back({1'b0, 1'b1, 3'd4, 1'b1});
    send(8'h00, 1); send(8'h02, 1); send(8'h10, 2); send(8'h20, 2);
    send(8'h31, 2);
    wait_flag("t7_bad_wait", 20);
    chk("t7_code", err_code, 3'd4);
    do_restart("t7_restart2");
`endif

    repeat (5) step();
    sim_done = 1'b1;
  endtask

  initial begin
    fork
      monitor_loop();
      stimulus();
    join
    chk("writes_left", wq.size(), 0);
    chk("status_left", sq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test required finish before 2000000");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/chip8_uart_loader.md
Name: chip8_uart_loader

Overview:
- Sequences a chip8 program image from the UART receiver into chip8 program RAM, then releases the CPU.
- Sits between the uart rx byte output and the RAM write port inside top; holds the CPU in reset for the whole load.
- Framing: 2-byte big-endian length, then N payload bytes written from BASE_ADDR upward.
- Guards the load with an inter-byte timeout and overrun and length checks.

Parameters:
- AW, 12: RAM address width.
- BASE_ADDR, 12'h200: address of the first payload byte.
- MAX_LEN, 3584: largest accepted payload length (BASE_ADDR+MAX_LEN must not exceed 2**AW).
- TIMEOUT_CYCLES, 1200000: maximum idle clocks between bytes once a frame has started.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous reset, active-high.
- rx_data_i  in  8  received byte.
- rx_valid_i  in  1  one-cycle strobe; rx_data_i valid.
- restart_i  in  1  pulse; from DONE/ERR, return to IDLE.
- mem_addr_o  out  AW  RAM write address.
- mem_data_o  out  8  RAM write data.
- mem_we_o  out  1  write request, held until acknowledged.
- mem_ack_i  in  1  RAM accepted the write this cycle.
- cpu_rst_o  out  1  holds chip8 CPU in reset.
- done_o  out  1  load completed successfully (level).
- err_o  out  1  load aborted (level).
- err_code_o  out  3  0 none, 1 length, 2 overrun, 3 timeout, 4 checksum.

Behaviour:
- Reset is asynchronous and active-high on rst_i; clk_i is the only clock.
- Reset values: state=IDLE, mem_addr_o=BASE_ADDR, mem_data_o=0, mem_we_o=0, cpu_rst_o=1, done_o=0, err_o=0, err_code_o=0, byte counter=0, timeout counter=0.
- Reset mid-load abandons the frame immediately. RAM contents already written are not cleared.
- States: IDLE, LEN_HI, LEN_LO, DATA, CSUM (macro only), DONE, ERR.
- IDLE: cpu_rst_o=1. The first rx_valid_i latches the length high byte and moves to LEN_LO. LEN_HI is an entry alias of IDLE and takes one cycle when re-entered via restart_i.
- LEN_LO: rx_valid_i completes len = {hi, lo}.
  - len==0: go to DONE, or CSUM with the macro.
  - len>MAX_LEN: go to ERR with code 1.
  - Otherwise: go to DATA with counter=len and mem_addr_o=BASE_ADDR.
- DATA:
  - rx_valid_i with mem_we_o=0: next cycle mem_data_o=rx_data_i and mem_we_o=1.
  - mem_we_o stays high until a cycle where mem_ack_i=1. The next cycle mem_we_o=0, mem_addr_o+1 and the counter decrements.
  - When the counter reaches 0 on ack, go to DONE (or CSUM).
  - rx_valid_i while mem_we_o=1 and mem_ack_i=0: ERR, code 2, and mem_we_o drops next cycle.
  - rx_valid_i in the same cycle as mem_ack_i is legal: the byte is captured and mem_we_o stays 1 with the incremented address.
- Timeout counter:
  - Clears on every rx_valid_i and on every state entry.
  - Increments each cycle in LEN_LO, DATA and CSUM.
  - Reaching TIMEOUT_CYCLES-1: ERR, code 3. Timeout has priority over a simultaneous ack; a simultaneous rx_valid_i clears the counter instead.
- DONE: cpu_rst_o=0 and done_o=1 from the cycle after entry. rx_valid_i is ignored.
- ERR: err_o=1, cpu_rst_o=1, mem_we_o=0. rx_valid_i is ignored.
- restart_i in DONE or ERR: next state IDLE; done_o, err_o and err_code_o clear; cpu_rst_o=1; mem_addr_o=BASE_ADDR. restart_i in any other state is ignored.
- Address never wraps, because MAX_LEN bounds it.

Optional Feature:
- Macro: CHIP8_LOADER_CSUM_EN.
- When defined: after the last payload ack, state CSUM waits for one byte.
  - The 8-bit modulo-256 sum of all payload bytes equals that byte: DONE.
  - It differs: ERR, code 4.
  - len==0 expects a checksum byte of 0x00.
- When undefined: there is no CSUM state or sum register, and code 4 never occurs.

Test Plan:
- Bytes 00 03 A1 B2 C3, with ack in the same cycle as we: writes 0x200=A1, 0x201=B2, 0x202=C3, each mem_we_o 1 cycle wide; then done_o=1, cpu_rst_o=0.
- Bytes 0E 01: err_o=1, err_code_o=1, no mem_we_o, cpu_rst_o=1.
- Length 00 02, mem_ack_i held low, second payload byte sent 5 cycles after the first: err_code_o=2, mem_we_o drops next cycle.
- Bytes 00 05 11, then silence for TIMEOUT_CYCLES (set to 100 in the bench): err_code_o=3; then restart_i followed by 00 00 gives done_o=1.
- Reset asserted mid-DATA after 2 of 4 bytes: all outputs return to reset values asynchronously, without waiting for a clock edge. A new frame 00 01 5A writes 0x200=5A.
- With CHIP8_LOADER_CSUM_EN: 00 02 10 20 30 gives done_o=1; 00 02 10 20 31 gives err_code_o=4.
